game_seq_ctrl: RTL and testbench

- Game-lifecycle sequencer for the 640x480 brick/paddle game.
- Drives the playfield engine's run enable (str), per-round reset pulse and speed/paddle-size select.
- Tracks lives and a two-digit BCD score, and times serve, miss and end-of-game pauses in video frames.
- Sits between the board buttons/switches, the playfield engine and the score/text overlay.

---
 rtl/game_pkg.sv | 55 +++++
 rtl/bcd_sat_cnt2.sv | 31 +++
 rtl/game_seq_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_game_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the brick/paddle game sequencer:
//   - state codes as seen by the score/text overlay, plus the FSM enum
//   - BCD score ceiling and a saturating two-digit BCD increment helper
//   - default frame-count constants for serve / miss / end-of-game pauses
//   - screen geometry shared with the playfield engine
// -----------------------------------------------------------------------------
package game_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] MISS  = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;
  localparam logic [2:0] WIN   = 3'd5;
  localparam logic [2:0] PAUSE = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_SERVE = SERVE,
    S_PLAY  = PLAY,
    S_MISS  = MISS,
    S_OVER  = OVER,
    S_WIN   = WIN,
    S_PAUSE = PAUSE
  } state_t;

  localparam logic [7:0] SCORE_MAX_BCD = 8'h99;

  localparam int LIVES_INIT_DEF   = 3;
  localparam int SERVE_FRAMES_DEF = 120;
  localparam int MISS_FRAMES_DEF  = 60;
  localparam int END_FRAMES_DEF   = 180;
  localparam int TMR_W_DEF        = 8;

  localparam int MAX_X = 640;
  localparam int MAX_Y = 480;

  // Two-digit BCD +1 that sticks at 99; the tens digit can never roll past 9
  // because the ceiling check happens first.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v != SCORE_MAX_BCD) begin
      if (v[3:0] == 4'd9) begin
        r = {v[7:4] + 4'd1, 4'd0};
      end else begin
        r = {v[7:4], v[3:0] + 4'd1};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_sat_cnt2.sv
// -----------------------------------------------------------------------------
// bcd_sat_cnt2
// Two-digit BCD up-counter, saturating at 99.
// Ports:
//   clk    - clock
//   reset  - asynchronous, active-high; clears the count to 00
//   clr    - synchronous clear (wins over inc)
//   inc    - count enable, one step per asserted cycle
//   q      - BCD value {tens, ones}
// -----------------------------------------------------------------------------
module bcd_sat_cnt2
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 8'h00;
    end else if (clr) begin
      q <= 8'h00;
    end else if (inc) begin
      q <= bcd_inc_sat(q);
    end
  end

endmodule

// File: rtl/game_seq_ctrl.sv
// -----------------------------------------------------------------------------
// game_seq_ctrl
// Game-lifecycle sequencer for the 640x480 brick/paddle game. Starts games,
// times serve / miss / end-of-game pauses in video frames, tracks lives and
// the BCD score, and drives the playfield engine's run enable and re-init.
//
// Ports:
//   clk         - system/pixel clock
//   reset       - asynchronous, active-high
//   frame_tick  - one-cycle pulse per video frame
//   btn_start   - start button level (rising edge detected here)
//   btn_pause   - pause button level, only with GAME_SEQ_PAUSE_EN defined
//   sw_level    - difficulty switches, latched at game start
//   hit         - one-cycle pulse per brick/paddle hit
//   miss        - one-cycle pulse when the ball is lost
//   clear       - one-cycle pulse when the last brick is removed
//   str         - ball-run enable to the engine (high only in PLAY)
//   game_rst    - one-cycle engine re-init pulse on entering SERVE
//   speed_sel   - latched difficulty
//   lives       - remaining lives
//   score       - BCD score {tens, ones}
//   state       - current state code for the overlay
//
// Build option: define GAME_SEQ_PAUSE_EN to add btn_pause and the PAUSE state.
// -----------------------------------------------------------------------------
module game_seq_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int MISS_FRAMES  = MISS_FRAMES_DEF,
  parameter int END_FRAMES   = END_FRAMES_DEF,
  parameter int TMR_W        = TMR_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_start,
`ifdef GAME_SEQ_PAUSE_EN
  input  logic       btn_pause,
`endif
  input  logic [1:0] sw_level,
  input  logic       hit,
  input  logic       miss,
  input  logic       clear,
  output logic       str,
  output logic       game_rst,
  output logic [1:0] speed_sel,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] state
);

  // Last timer value of each pause; the pause ends on the frame_tick seen
  // while the timer holds this value.
  localparam logic [TMR_W-1:0] SERVE_LAST = TMR_W'(SERVE_FRAMES - 1);
  localparam logic [TMR_W-1:0] MISS_LAST  = TMR_W'(MISS_FRAMES - 1);
  localparam logic [TMR_W-1:0] END_LAST   = TMR_W'(END_FRAMES - 1);
  localparam logic [1:0]       LIVES_LOAD = 2'(LIVES_INIT);

  state_t           cur_state, nxt_state;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [1:0]       lives_nxt, speed_nxt;
  logic             game_rst_nxt;
  logic             score_clr, score_inc;
  logic             btn_start_d;
  logic             start_edge, pause_edge, start_go;

  assign start_edge = btn_start & ~btn_start_d;

`ifdef GAME_SEQ_PAUSE_EN
  logic btn_pause_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_pause_d <= 1'b0;
    end else begin
      btn_pause_d <= btn_pause;
    end
  end

  assign pause_edge = btn_pause & ~btn_pause_d;
`else
  assign pause_edge = 1'b0;
`endif

  // A pause edge suppresses a coincident start edge everywhere.
  assign start_go = start_edge & ~pause_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_start_d <= 1'b0;
    end else begin
      btn_start_d <= btn_start;
    end
  end

  always_comb begin
    nxt_state    = cur_state;
    timer_nxt    = timer;
    lives_nxt    = lives;
    speed_nxt    = speed_sel;
    game_rst_nxt = 1'b0;
    score_clr    = 1'b0;
    score_inc    = 1'b0;

    case (cur_state)
      S_IDLE: begin
        if (start_go) begin
          speed_nxt    = sw_level;
          lives_nxt    = LIVES_LOAD;
          score_clr    = 1'b1;
          timer_nxt    = '0;
          game_rst_nxt = 1'b1;
          nxt_state    = S_SERVE;
        end
      end

      S_SERVE: begin
        if (start_go) begin
          timer_nxt = '0;
          nxt_state = S_PLAY;
        end else if (frame_tick) begin
          if (timer == SERVE_LAST) begin
            timer_nxt = '0;
            nxt_state = S_PLAY;
          end else begin
            timer_nxt = timer + TMR_W'(1);
          end
        end
      end

      S_PLAY: begin
        if (pause_edge) begin
          nxt_state = S_PAUSE;
        end else begin
          score_inc = hit;
          // miss outranks clear when both arrive together
          if (miss) begin
            lives_nxt = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
            timer_nxt = '0;
            nxt_state = S_MISS;
          end else if (clear) begin
            timer_nxt = '0;
            nxt_state = S_WIN;
          end
        end
      end

      S_MISS: begin
        if (lives == 2'd0) begin
          timer_nxt = '0;
          nxt_state = S_OVER;
        end else if (frame_tick) begin
          if (timer == MISS_LAST) begin
            timer_nxt    = '0;
            game_rst_nxt = 1'b1;
            nxt_state    = S_SERVE;
          end else begin
            timer_nxt = timer + TMR_W'(1);
          end
        end
      end

      S_OVER, S_WIN: begin
        if (frame_tick) begin
          if (timer == END_LAST) begin
            timer_nxt = '0;
            nxt_state = S_IDLE;
          end else begin
            timer_nxt = timer + TMR_W'(1);
          end
        end
      end

      S_PAUSE: begin
        if (pause_edge) begin
          nxt_state = S_PLAY;
        end
      end

      default: begin
        timer_nxt = '0;
        nxt_state = S_IDLE;
      end
    endcase
  end

  // All outputs come straight from flops; str is precomputed from the next
  // state so it is aligned with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_IDLE;
      timer     <= '0;
      str       <= 1'b0;
      game_rst  <= 1'b0;
      speed_sel <= 2'd0;
      lives     <= 2'd0;
    end else begin
      cur_state <= nxt_state;
      timer     <= timer_nxt;
      str       <= (nxt_state == S_PLAY);
      game_rst  <= game_rst_nxt;
      speed_sel <= speed_nxt;
      lives     <= lives_nxt;
    end
  end

  assign state = cur_state;

  bcd_sat_cnt2 u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .q     (score)
  );

endmodule

// File: tb/tb_game_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_seq_ctrl
// Self-checking bench for game_seq_ctrl. A frame-counting game model tracks
// what the outputs must be every cycle; directed sequences walk a full game,
// saturation, a game over, a miss+clear+hit collision, early serve and a
// mid-serve reset. The pause sequence runs when GAME_SEQ_PAUSE_EN is defined.
// -----------------------------------------------------------------------------
module tb_game_seq_ctrl;

  localparam int SERVE_N = 120;
  localparam int MISS_N  = 60;
  localparam int END_N   = 180;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, btn_start, hit, miss, clear;
  logic [1:0] sw_level;
  logic       str, game_rst;
  logic [1:0] speed_sel, lives;
  logic [7:0] score;
  logic [2:0] state;
`ifdef GAME_SEQ_PAUSE_EN
  logic       btn_pause;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_start  (btn_start),
`ifdef GAME_SEQ_PAUSE_EN
    .btn_pause  (btn_pause),
`endif
    .sw_level   (sw_level),
    .hit        (hit),
    .miss       (miss),
    .clear      (clear),
    .str        (str),
    .game_rst   (game_rst),
    .speed_sel  (speed_sel),
    .lives      (lives),
    .score      (score),
    .state      (state)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  // Game model: counts frames seen in each pause and the decimal score.
  int m_state, m_frames, m_lives, m_score, m_speed;
  bit m_str, m_rst, m_start_prev, m_pause_prev;

  always @(posedge clk or posedge reset) begin : model
    bit se, pe;
    if (reset) begin
      m_state = 0; m_frames = 0; m_lives = 0; m_score = 0; m_speed = 0;
      m_str = 0; m_rst = 0; m_start_prev = 0; m_pause_prev = 0;
    end else begin
      pe = 0;
`ifdef GAME_SEQ_PAUSE_EN
      pe = btn_pause && !m_pause_prev;
      m_pause_prev = btn_pause;
`endif
      se = btn_start && !m_start_prev && !pe;
      m_start_prev = btn_start;
      m_rst = 0;
      case (m_state)
        0: if (se) begin
             m_speed = sw_level; m_lives = 3; m_score = 0; m_frames = 0;
             m_rst = 1; m_state = 1;
           end
        1: if (se) begin
             m_state = 2; m_frames = 0;
           end else if (frame_tick) begin
             m_frames++;
             if (m_frames == SERVE_N) begin m_state = 2; m_frames = 0; end
           end
        2: if (pe) m_state = 6;
           else begin
             if (hit && m_score < 99) m_score++;
             if (miss) begin
               if (m_lives > 0) m_lives--;
               m_state = 3; m_frames = 0;
             end else if (clear) begin
               m_state = 5; m_frames = 0;
             end
           end
        3: if (m_lives == 0) begin
             m_state = 4; m_frames = 0;
           end else if (frame_tick) begin
             m_frames++;
             if (m_frames == MISS_N) begin m_state = 1; m_frames = 0; m_rst = 1; end
           end
        4, 5: if (frame_tick) begin
             m_frames++;
             if (m_frames == END_N) begin m_state = 0; m_frames = 0; end
           end
        6: if (pe) m_state = 2;
        default: m_state = 0;
      endcase
      m_str = (m_state == 2);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("cyc_state", int'(state), m_state);
      checkOutput("cyc_str", int'(str), int'(m_str));
      checkOutput("cyc_game_rst", int'(game_rst), int'(m_rst));
      checkOutput("cyc_speed_sel", int'(speed_sel), m_speed);
      checkOutput("cyc_lives", int'(lives), m_lives);
      checkOutput("cyc_score", int'(score), to_bcd(m_score));
    end
  end

  // One full clock of stimulus; called and returning at a falling edge.
  task automatic applyStimulus(input bit st, input bit ht, input bit ms,
                               input bit cl, input bit ft);
    btn_start  = st;
    hit        = ht;
    miss       = ms;
    clear      = cl;
    frame_tick = ft;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic hits(input int n);
    repeat (n) applyStimulus(0, 1, 0, 0, 0);
  endtask

  task automatic framesUntilStr(output int n);
    n = 0;
    for (int i = 0; i < 250; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      n++;
      if (str) break;
    end
  endtask

  task automatic framesUntilRst(output int n);
    n = 0;
    for (int i = 0; i < 250; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      n++;
      if (game_rst) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; sw_level = 2'b00;
    btn_start = 0; hit = 0; miss = 0; clear = 0; frame_tick = 0;
`ifdef GAME_SEQ_PAUSE_EN
    btn_pause = 0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_str", int'(str), 0);
    checkOutput("rst_game_rst", int'(game_rst), 0);
    checkOutput("rst_speed", int'(speed_sel), 0);
    checkOutput("rst_lives", int'(lives), 0);
    checkOutput("rst_score", int'(score), 'h00);
    reset = 1'b0;
    repeat (2) applyStimulus(0, 0, 0, 0, 0);

    // Game start
    sw_level = 2'b01;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("start_state", int'(state), 1);
    checkOutput("start_game_rst", int'(game_rst), 1);
    checkOutput("start_speed", int'(speed_sel), 1);
    checkOutput("start_lives", int'(lives), 3);
    checkOutput("start_score", int'(score), 'h00);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("start_rst_drop", int'(game_rst), 0);
    framesUntilStr(n);
    checkOutput("serve_frames", n, 120);
    checkOutput("serve_play", int'(state), 2);

    // Scoring and saturation
    hits(12);
    checkOutput("score_12", int'(score), 'h12);
    checkOutput("model_score_12", to_bcd(m_score), 'h12);
    hits(86);
    checkOutput("score_98", int'(score), 'h98);
    hits(3);
    checkOutput("score_sat", int'(score), 'h99);

    // First miss, re-serve
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("miss1_state", int'(state), 3);
    checkOutput("miss1_lives", int'(lives), 2);
    checkOutput("miss1_str", int'(str), 0);
    framesUntilRst(n);
    checkOutput("miss_frames", n, 60);
    checkOutput("miss_to_serve", int'(state), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("miss_rst_once", int'(game_rst), 0);
    framesUntilStr(n);
    checkOutput("reserve_frames", n, 120);

    // Second and third miss -> game over
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("miss2_lives", int'(lives), 1);
    frames(60);
    checkOutput("miss2_serve", int'(state), 1);
    framesUntilStr(n);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("miss3_lives", int'(lives), 0);
    checkOutput("miss3_state", int'(state), 3);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("over_state", int'(state), 4);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("over_ignores_start", int'(state), 4);
    frames(179);
    checkOutput("over_hold", int'(state), 4);
    frames(1);
    checkOutput("over_to_idle", int'(state), 0);
    checkOutput("over_score_kept", int'(score), 'h99);

    // New game with early serve; miss+clear+hit collision
    sw_level = 2'b10;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("g2_speed", int'(speed_sel), 2);
    checkOutput("g2_score_clr", int'(score), 'h00);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("early_serve", int'(state), 2);
    checkOutput("early_str", int'(str), 1);
    applyStimulus(0, 0, 0, 0, 0);
    hits(5);
    checkOutput("g2_score5", int'(score), 'h05);
    applyStimulus(0, 1, 1, 1, 0);
    checkOutput("collide_state", int'(state), 3);
    checkOutput("collide_score", int'(score), 'h06);
    checkOutput("collide_lives", int'(lives), 2);

    // Reset in the middle of a serve
    framesUntilRst(n);
    checkOutput("g2_miss_frames", n, 60);
    frames(10);
    #3 reset = 1'b1;
    #1;
    checkOutput("midrst_state", int'(state), 0);
    checkOutput("midrst_game_rst", int'(game_rst), 0);
    checkOutput("midrst_lives", int'(lives), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("postrst_state", int'(state), 0);
    checkOutput("postrst_game_rst", int'(game_rst), 0);

`ifdef GAME_SEQ_PAUSE_EN
    sw_level = 2'b11;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    hits(2);
    btn_pause = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    btn_pause = 1'b0;
    checkOutput("pause_state", int'(state), 6);
    checkOutput("pause_str", int'(str), 0);
    hits(3);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("pause_score_frozen", int'(score), 'h02);
    checkOutput("pause_lives_frozen", int'(lives), 3);
    btn_pause = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    btn_pause = 1'b0;
    checkOutput("resume_state", int'(state), 2);
    checkOutput("resume_str", int'(str), 1);
    checkOutput("resume_score", int'(score), 'h02);
    applyStimulus(0, 0, 0, 0, 0);
`endif

    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
